// File: rtl/vram_arbiter_if.sv
// Bus bundle between the bitmap VRAM arbiter and its three requesters
// (video fetch, game CPU, auxiliary port) plus the single-port RAM.
// slave  : arbiter side.
// master : requester / RAM side.
interface vram_arbiter_if #(
   parameter int AW = 15,
   parameter int DW = 8
);
   // video refresh fetch (read-only)
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_valid;
   logic [DW-1:0] vid_rdata;

   // game CPU
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;

   // auxiliary port (OSD / hiscore / debug)
   logic          aux_req;
   logic          aux_we;
   logic [AW-1:0] aux_addr;
   logic [DW-1:0] aux_wdata;
   logic          aux_ack;
   logic [DW-1:0] aux_rdata;

   // single-port synchronous RAM
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  vid_req, vid_addr,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  aux_req, aux_we, aux_addr, aux_wdata,
      input  ram_rdata,
      output vid_valid, vid_rdata,
      output cpu_ack, cpu_rdata,
      output aux_ack, aux_rdata,
      output ram_addr, ram_we, ram_wdata
   );

   modport master (
      output vid_req, vid_addr,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output aux_req, aux_we, aux_addr, aux_wdata,
      output ram_rdata,
      input  vid_valid, vid_rdata,
      input  cpu_ack, cpu_rdata,
      input  aux_ack, aux_rdata,
      input  ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Crystal Castles bitmap VRAM arbiter.
// Each cycle the single-port RAM goes to one requester: video always wins,
// then CPU or aux. The owner of the access is registered, and the owner sees
// a one-cycle ack/valid the next cycle with rdata taken straight from the RAM.
// Build option: define VRAM_ARB_RR_EN for round-robin CPU/aux arbitration;
// when it is left undefined the CPU has fixed priority over aux.
module vram_arbiter #(
   parameter int AW = 15,
   parameter int DW = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   vram_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_VID,
      OWN_CPU,
      OWN_AUX
   } owner_e;

   owner_e        grant;
   owner_e        owner;
   logic          cpu_busy;
   logic          aux_busy;
   logic          cpu_elig;
   logic          aux_elig;
   logic          vid_ack;
   logic          cpu_ack;
   logic          aux_ack;
   logic [AW-1:0] sel_addr;
   logic          sel_we;
   logic [DW-1:0] sel_wdata;
   logic [DW-1:0] vid_rdata_q;
   logic [DW-1:0] cpu_rdata_q;
   logic [DW-1:0] aux_rdata_q;

`ifdef VRAM_ARB_RR_EN
   typedef enum logic {
      LG_CPU,
      LG_AUX
   } last_e;

   last_e last_grant;
`endif

   // A port with its ack still outstanding cannot be granted again.
   assign cpu_elig = bus.cpu_req & ~cpu_busy;
   assign aux_elig = bus.aux_req & ~aux_busy;

   // Choose this cycle's owner: video first, then CPU/aux.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first;
      // a path that skips an assignment would otherwise infer a latch.
      grant = OWN_NONE;
      if (reset_n) begin
         if (bus.vid_req) begin
            grant = OWN_VID;
         end
`ifdef VRAM_ARB_RR_EN
         else if (cpu_elig && aux_elig) begin
            // tie goes to whichever port was not served last
            if (last_grant == LG_AUX) grant = OWN_CPU;
            else                      grant = OWN_AUX;
         end
`endif
         else if (cpu_elig) begin
            grant = OWN_CPU;
         end
         else if (aux_elig) begin
            grant = OWN_AUX;
         end
      end
   end

   // Steer the granted port onto the RAM; idle cycles drive all zeros.
   always_comb begin
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_wdata = '0;
      case (grant)
         OWN_VID: begin
            sel_addr = bus.vid_addr;
         end
         OWN_CPU: begin
            sel_addr  = bus.cpu_addr;
            sel_we    = bus.cpu_we;
            sel_wdata = bus.cpu_wdata;
         end
         OWN_AUX: begin
            sel_addr  = bus.aux_addr;
            sel_we    = bus.aux_we;
            sel_wdata = bus.aux_wdata;
         end
         default: ;
      endcase
   end

   assign bus.ram_addr  = sel_addr;
   // grant is already NONE in reset; the extra gate keeps the strobe safe
   assign bus.ram_we    = sel_we & reset_n;
   assign bus.ram_wdata = sel_wdata;

   // Acks follow the registered owner; reset drops any pending one at once.
   assign vid_ack = reset_n & (owner == OWN_VID);
   assign cpu_ack = reset_n & (owner == OWN_CPU);
   assign aux_ack = reset_n & (owner == OWN_AUX);

   assign bus.vid_valid = vid_ack;
   assign bus.cpu_ack   = cpu_ack;
   assign bus.aux_ack   = aux_ack;

   // The acked port sees live RAM data; the others show their last read.
   assign bus.vid_rdata = vid_ack ? bus.ram_rdata : vid_rdata_q;
   assign bus.cpu_rdata = cpu_ack ? bus.ram_rdata : cpu_rdata_q;
   assign bus.aux_rdata = aux_ack ? bus.ram_rdata : aux_rdata_q;

   // Owner FSM, busy flags, rdata holding registers and round-robin state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         owner       <= OWN_NONE;
         cpu_busy    <= 1'b0;
         aux_busy    <= 1'b0;
         vid_rdata_q <= '0;
         cpu_rdata_q <= '0;
         aux_rdata_q <= '0;
`ifdef VRAM_ARB_RR_EN
         last_grant  <= LG_AUX;
`endif
      end else begin
         owner <= grant;

         if (grant == OWN_CPU) cpu_busy <= 1'b1;
         else if (cpu_ack)     cpu_busy <= 1'b0;

         if (grant == OWN_AUX) aux_busy <= 1'b1;
         else if (aux_ack)     aux_busy <= 1'b0;

         if (vid_ack) vid_rdata_q <= bus.ram_rdata;
         if (cpu_ack) cpu_rdata_q <= bus.ram_rdata;
         if (aux_ack) aux_rdata_q <= bus.ram_rdata;

`ifdef VRAM_ARB_RR_EN
         if (grant == OWN_CPU)      last_grant <= LG_CPU;
         else if (grant == OWN_AUX) last_grant <= LG_AUX;
`endif
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter. A synchronous RAM model sits on the
// RAM side; every expected ack/valid (port, cycle, data) is pushed to a
// scoreboard when stimulus is driven, and a negedge monitor records what
// the DUT actually returned. Each test task then pops and compares.
module tb_vram_arbiter;

   localparam int AW = 15;
   localparam int DW = 8;

   typedef enum logic [1:0] {P_VID, P_CPU, P_AUX} port_e;

   typedef struct {
      port_e         port;
      int            cyc;
      logic          chk;
      logic [DW-1:0] data;
   } ev_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_checks;
   int   n_fail;

   ev_t  sb[$];
   ev_t  obs[$];

   logic [DW-1:0] mem [0:(1<<AW)-1];

   vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   vram_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Synchronous single-port RAM, read-before-write.
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   // Record every ack/valid the DUT returns.
   always @(negedge clk) begin
      if (bus.vid_valid === 1'b1) obs.push_back('{P_VID, cyc, 1'b1, bus.vid_rdata});
      if (bus.cpu_ack   === 1'b1) obs.push_back('{P_CPU, cyc, 1'b1, bus.cpu_rdata});
      if (bus.aux_ack   === 1'b1) obs.push_back('{P_AUX, cyc, 1'b1, bus.aux_rdata});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a[7:0] ^ a[14:7] ^ 8'hA5;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.vid_req   = 1'b0;
      bus.vid_addr  = '0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.aux_req   = 1'b0;
      bus.aux_we    = 1'b0;
      bus.aux_addr  = '0;
      bus.aux_wdata = '0;
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      ev_t e;
      ev_t o;
      int  c;
      idle_inputs();
      reset_n       = 1'b0;
      bus.vid_req   = 1'b1;
      bus.cpu_req   = 1'b1;
      bus.aux_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.aux_we    = 1'b1;
      bus.vid_addr  = 15'h0042;
      bus.cpu_addr  = 15'h0011;
      bus.aux_addr  = 15'h0022;
      bus.cpu_wdata = 8'hFF;
      bus.aux_wdata = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         n_checks++;
         if ({bus.vid_valid, bus.cpu_ack, bus.aux_ack, bus.ram_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: {valid,cack,aack,we}=%b expected 0000", {bus.vid_valid, bus.cpu_ack, bus.aux_ack, bus.ram_we});
         end
         n_checks++;
         if ({bus.vid_rdata, bus.cpu_rdata, bus.aux_rdata} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 000000", {bus.vid_rdata, bus.cpu_rdata, bus.aux_rdata});
         end
      end
      // first cycle out of reset: video wins, CPU/aux keep requesting reads
      step();
      obs.delete();
      reset_n    = 1'b1;
      bus.cpu_we = 1'b0;
      bus.aux_we = 1'b0;
      c = cyc;
      @(negedge clk);
      n_checks++;
      if (bus.ram_addr !== 15'h0042 || bus.ram_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_grant: ram_addr=%h we=%b expected 0042 we=0", bus.ram_addr, bus.ram_we);
      end
      sb.push_back('{P_VID, c + 1, 1'b1, pat(15'h0042)});
      // video drops; CPU must win the first tie after reset
      step();
      bus.vid_req = 1'b0;
      sb.push_back('{P_CPU, c + 2, 1'b1, pat(15'h0011)});
      sb.push_back('{P_AUX, c + 3, 1'b1, pat(15'h0022)});
      step();
      step();
      bus.cpu_req = 1'b0;
      bus.aux_req = 1'b0;
      step();
      step();
      while (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         if (obs.size() == 0) begin
            n_fail++;
            $display("FAIL reset_sb: no ack, expected %s at cycle %0d", e.port.name(), e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               n_fail++;
               $display("FAIL reset_sb: got %s cyc %0d data %h expected %s cyc %0d data %h", o.port.name(), o.cyc, o.data, e.port.name(), e.cyc, e.data);
            end
         end
      end
      n_checks++;
      if (obs.size() != 0) begin
         n_fail++;
         $display("FAIL reset_sb_extra: %0d unexpected acks, expected 0", obs.size());
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_video_priority();
      ev_t e;
      ev_t o;
      int  c;
      idle_inputs();
      step();
      obs.delete();
      bus.vid_req  = 1'b1;
      bus.vid_addr = 15'h0100;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 15'h0200;
      c = cyc;
      @(negedge clk);
      n_checks++;
      if (bus.ram_addr !== 15'h0100) begin
         n_fail++;
         $display("FAIL vidpri_grant: ram_addr=%h expected 0100", bus.ram_addr);
      end
      sb.push_back('{P_VID, c + 1, 1'b1, pat(15'h0100)});
      step();
      bus.vid_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.ram_addr !== 15'h0200) begin
         n_fail++;
         $display("FAIL vidpri_cpu_grant: ram_addr=%h expected 0200", bus.ram_addr);
      end
      sb.push_back('{P_CPU, c + 2, 1'b1, pat(15'h0200)});
      step();
      @(negedge clk);
      // CPU busy in its ack cycle: nothing granted, bus idles at zero
      n_checks++;
      if (bus.ram_addr !== 15'h0000 || bus.ram_we !== 1'b0 || bus.ram_wdata !== 8'h00) begin
         n_fail++;
         $display("FAIL vidpri_idle: addr=%h we=%b wdata=%h expected 0000/0/00", bus.ram_addr, bus.ram_we, bus.ram_wdata);
      end
      n_checks++;
      if (bus.vid_rdata !== pat(15'h0100)) begin
         n_fail++;
         $display("FAIL vidpri_hold: vid_rdata=%h expected %h", bus.vid_rdata, pat(15'h0100));
      end
      step();
      bus.cpu_req = 1'b0;
      step();
      step();
      while (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         if (obs.size() == 0) begin
            n_fail++;
            $display("FAIL vidpri_sb: no ack, expected %s at cycle %0d", e.port.name(), e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               n_fail++;
               $display("FAIL vidpri_sb: got %s cyc %0d data %h expected %s cyc %0d data %h", o.port.name(), o.cyc, o.data, e.port.name(), e.cyc, e.data);
            end
         end
      end
      n_checks++;
      if (obs.size() != 0) begin
         n_fail++;
         $display("FAIL vidpri_sb_extra: %0d unexpected acks, expected 0", obs.size());
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_cpu_write_read();
      ev_t e;
      ev_t o;
      int  c;
      idle_inputs();
      step();
      obs.delete();
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 15'h1234;
      bus.cpu_wdata = 8'h5A;
      c = cyc;
      @(negedge clk);
      n_checks++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 15'h1234, 8'h5A}) begin
         n_fail++;
         $display("FAIL cpu_write_bus: we=%b addr=%h wdata=%h expected 1/1234/5a", bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      sb.push_back('{P_CPU, c + 1, 1'b0, 8'h00});
      step();
      step();
      bus.cpu_we = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.ram_we !== 1'b0 || bus.ram_addr !== 15'h1234) begin
         n_fail++;
         $display("FAIL cpu_read_bus: we=%b addr=%h expected 0/1234", bus.ram_we, bus.ram_addr);
      end
      sb.push_back('{P_CPU, c + 3, 1'b1, 8'h5A});
      step();
      step();
      bus.cpu_req   = 1'b0;
      bus.aux_req   = 1'b1;
      bus.aux_we    = 1'b1;
      bus.aux_addr  = 15'h0777;
      bus.aux_wdata = 8'h3C;
      @(negedge clk);
      n_checks++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 15'h0777, 8'h3C}) begin
         n_fail++;
         $display("FAIL aux_write_bus: we=%b addr=%h wdata=%h expected 1/0777/3c", bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      sb.push_back('{P_AUX, c + 5, 1'b0, 8'h00});
      step();
      step();
      bus.aux_req  = 1'b0;
      bus.aux_we   = 1'b0;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 15'h0777;
      sb.push_back('{P_CPU, c + 7, 1'b1, 8'h3C});
      step();
      step();
      bus.cpu_req  = 1'b0;
      bus.aux_req  = 1'b1;
      bus.aux_addr = 15'h1234;
      sb.push_back('{P_AUX, c + 9, 1'b1, 8'h5A});
      step();
      step();
      bus.aux_req = 1'b0;
      step();
      while (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         if (obs.size() == 0) begin
            n_fail++;
            $display("FAIL wr_rd_sb: no ack, expected %s at cycle %0d", e.port.name(), e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               n_fail++;
               $display("FAIL wr_rd_sb: got %s cyc %0d data %h expected %s cyc %0d data %h", o.port.name(), o.cyc, o.data, e.port.name(), e.cyc, e.data);
            end
         end
      end
      n_checks++;
      if (obs.size() != 0) begin
         n_fail++;
         $display("FAIL wr_rd_sb_extra: %0d unexpected acks, expected 0", obs.size());
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_arbitration();
      ev_t           e;
      ev_t           o;
      int            c;
      port_e         first;
      port_e         second;
      logic [AW-1:0] exp_addr;
      idle_inputs();
      step();
      obs.delete();
      // both held with no video: CPU, aux, CPU, aux ... (last served was aux)
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 15'h0011;
      bus.aux_req  = 1'b1;
      bus.aux_addr = 15'h0022;
      c = cyc;
      for (int k = 0; k < 8; k++) begin
         if (k != 0) step();
         @(negedge clk);
         exp_addr = (k % 2 == 0) ? 15'h0011 : 15'h0022;
         n_checks++;
         if (bus.ram_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL arb_alt[%0d]: ram_addr=%h expected %h", k, bus.ram_addr, exp_addr);
         end
         if (k % 2 == 0) sb.push_back('{P_CPU, c + k + 1, 1'b1, pat(15'h0011)});
         else            sb.push_back('{P_AUX, c + k + 1, 1'b1, pat(15'h0022)});
      end
      step();
      bus.cpu_req = 1'b0;
      bus.aux_req = 1'b0;
      step();
      // CPU alone, then a simultaneous tie
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 15'h0033;
      c = cyc;
      sb.push_back('{P_CPU, c + 1, 1'b1, pat(15'h0033)});
      step();
      step();
      bus.cpu_req = 1'b0;
      step();
      bus.cpu_req  = 1'b1;
      bus.aux_req  = 1'b1;
      bus.aux_addr = 15'h0044;
`ifdef VRAM_ARB_RR_EN
      first  = P_AUX;
      second = P_CPU;
`else
      first  = P_CPU;
      second = P_AUX;
`endif
      exp_addr = (first == P_CPU) ? 15'h0033 : 15'h0044;
      @(negedge clk);
      n_checks++;
      if (bus.ram_addr !== exp_addr) begin
         n_fail++;
         $display("FAIL arb_tie: ram_addr=%h expected %h", bus.ram_addr, exp_addr);
      end
      sb.push_back('{first,  c + 4, 1'b1, (first  == P_CPU) ? pat(15'h0033) : pat(15'h0044)});
      sb.push_back('{second, c + 5, 1'b1, (second == P_CPU) ? pat(15'h0033) : pat(15'h0044)});
      step();
      step();
      bus.cpu_req = 1'b0;
      bus.aux_req = 1'b0;
      step();
      step();
      while (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         if (obs.size() == 0) begin
            n_fail++;
            $display("FAIL arb_sb: no ack, expected %s at cycle %0d", e.port.name(), e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               n_fail++;
               $display("FAIL arb_sb: got %s cyc %0d data %h expected %s cyc %0d data %h", o.port.name(), o.cyc, o.data, e.port.name(), e.cyc, e.data);
            end
         end
      end
      n_checks++;
      if (obs.size() != 0) begin
         n_fail++;
         $display("FAIL arb_sb_extra: %0d unexpected acks, expected 0", obs.size());
      end
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset_mid_access();
      ev_t e;
      ev_t o;
      int  c;
      idle_inputs();
      step();
      obs.delete();
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 15'h0055;
      c = cyc;
      step();
      // reset in the would-be ack cycle, with an aux write pending
      reset_n       = 1'b0;
      bus.aux_req   = 1'b1;
      bus.aux_we    = 1'b1;
      bus.aux_addr  = 15'h0066;
      bus.aux_wdata = 8'h99;
      @(negedge clk);
      n_checks++;
      if (bus.cpu_ack !== 1'b0 || bus.ram_we !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_drop: cpu_ack=%b ram_we=%b expected 0/0", bus.cpu_ack, bus.ram_we);
      end
      step();
      reset_n     = 1'b1;
      bus.aux_req = 1'b0;
      bus.aux_we  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.ram_addr !== 15'h0055) begin
         n_fail++;
         $display("FAIL midrst_regrant: ram_addr=%h expected 0055", bus.ram_addr);
      end
      sb.push_back('{P_CPU, c + 3, 1'b1, pat(15'h0055)});
      step();
      step();
      bus.cpu_req = 1'b0;
      step();
      step();
      while (sb.size() != 0) begin
         e = sb.pop_front();
         n_checks++;
         if (obs.size() == 0) begin
            n_fail++;
            $display("FAIL midrst_sb: no ack, expected %s at cycle %0d", e.port.name(), e.cyc);
         end else begin
            o = obs.pop_front();
            if (o.port !== e.port || o.cyc != e.cyc || (e.chk && o.data !== e.data)) begin
               n_fail++;
               $display("FAIL midrst_sb: got %s cyc %0d data %h expected %s cyc %0d data %h", o.port.name(), o.cyc, o.data, e.port.name(), e.cyc, e.data);
            end
         end
      end
      n_checks++;
      if (obs.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_sb_extra: %0d unexpected acks, expected 0", obs.size());
      end
   endtask

   // ---------------------------------------------------------------------
   initial begin
      cyc      = 0;
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      idle_inputs();
      for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i[AW-1:0]);

      test_reset();
      test_video_priority();
      test_cpu_write_read();
      test_arbitration();
      test_reset_mid_access();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
